axis_mii_rx: RTL and testbench
==============================

Name: axis_mii_rx

Overview:
- 100M MII receive MAC, the counterpart of the TX MAC.
- Samples MII RX nibbles on the shared nibble clock-enable and finds the preamble/SFD.
- Assembles bytes, checks FCS, length and alignment, and emits frame data as an AXI stream with per-frame status pulses.
- Sits between the PHY RX pins (via the MII clock-enable generator) and the RX FIFO. The FIFO must always accept data: there is no backpressure.

Parameters:
- MAX_FRAME_BYTES, 1518: largest legal frame, DA through FCS inclusive.
- MIN_FRAME_BYTES, 64: smallest legal frame, DA through FCS inclusive.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- mii_rx_ce  input  1  one-cycle strobe; MII RX signals are valid this cycle
- mii_rx_dv  input  1  MII receive data valid
- mii_rx_er  input  1  MII receive error
- mii_rxd  input  4  MII receive nibble, low nibble of each byte first
- axis_data  output  8  received byte
- axis_valid  output  1  one-cycle beat strobe; no ready, sink must accept
- axis_last  output  1  final data byte of the frame
- axis_err  output  1  frame bad; valid only with axis_last
- frame_ok  output  1  pulse: good frame received
- fcs_error  output  1  pulse: CRC residue mismatch
- frame_error  output  1  pulse: rx_er, odd nibble count, runt, or bad preamble
- too_long  output  1  pulse: frame exceeded MAX_FRAME_BYTES

Behaviour:
- Reset:
  - All outputs 0.
  - State DROP, so a frame already in progress at reset release is ignored until mii_rx_dv is sampled low.
- Sampling: all MII inputs are sampled only on cycles with mii_rx_ce=1. Other cycles only drain pipeline registers.
- States:
  - IDLE: on ce&&dv: rxd==5 -> PREAMBLE; else -> DROP and pulse frame_error.
  - PREAMBLE:
    - ce&&dv&&rxd==5: stay.
    - ce&&dv&&rxd==D: SFD high nibble seen -> DATA. Clear byte counter, nibble phase and error flag; CRC state = 32'hffffffff.
    - any other nibble -> DROP and pulse frame_error.
    - ce&&!dv -> IDLE, no status.
  - DATA, on ce&&dv:
    - Store the low nibble or complete the byte with the high nibble.
    - A completed byte updates the CRC (lfsr instance configured identically to TX: poly 04c11db7, Galois, reflected, 8-bit) and increments the byte counter, 11 bits, saturating.
    - mii_rx_er=1 sets the sticky error flag.
  - DATA, on ce&&!dv (end of frame):
    - pending byte exists -> emit it with axis_last=1.
    - axis_err = fcs mismatch | error flag | odd nibble | runt (count < MIN_FRAME_BYTES).
    - Exactly one status pulse in that same cycle, priority: frame_error > fcs_error > frame_ok.
    - No pending byte (count ≤ 4) -> no beat, frame_error pulse only.
    - -> IDLE.
  - DROP: wait for ce&&!dv -> IDLE.
- Pipeline:
  - 4-byte FCS delay line plus a 1-byte pending register.
  - Each completed byte shifts in. Once count ≥ 5, the byte displaced into pending emits the previous pending as a beat, axis_last=0.
  - Beat appears the cycle after the ce that completed the byte.
  - The FCS is never emitted.
- FCS check: CRC state after the final FCS byte must equal CRC_RESIDUE (32'hdebb20e3).
- Oversize:
  - The byte making count = MAX_FRAME_BYTES+1 emits pending with last=1, err=1, plus too_long and frame_error pulses.
  - -> DROP; the remainder is discarded.
- Simultaneous events:
  - rx_er on the final nibble counts.
  - Oversize takes precedence over end-of-frame evaluation.
- Invariant: at most one axis_last per frame; axis_valid never asserts outside DATA or the end-of-frame cycle.

Optional Feature:
- Macro AXIS_MII_RX_KEEP_FCS_EN.
- Defined:
  - The delay line shrinks to pending only; the 4 FCS bytes are emitted as data.
  - axis_last falls on the last FCS byte.
  - The runt check is unchanged.
- Undefined: FCS stripped as above (default).

Decomposition:
- Shared package: CRC_INIT, CRC_POLY, CRC_RESIDUE, DATA_PREAMBLE (8'h55), DATA_SFD (8'hd5), MIN/MAX frame constants. These are shared with the TX MAC.
- No new sub-module: reuse the existing lfsr module for the CRC. Nibble assembly and the delay line are too small to split out.

Test Plan:
- Loopback from TX MAC, 60-byte payload (64-byte frame) -> 60 beats, last on the 60th, err=0, frame_ok once.
- Same frame with bit 0 of byte 20 flipped on mii_rxd -> 60 beats, last with err=1, fcs_error pulse, no frame_ok.
- mii_rx_er held for one ce at byte 30 of a 100-byte frame -> all 96 data beats, last err=1, frame_error.
- 1519-byte frame -> too_long+frame_error, last with err=1 at 1514th beat (byte 1519 minus 4 delayed + pending), remaining nibbles ignored, IDLE after dv low.
- Frame ending on an odd nibble, and a 40-byte runt with valid FCS -> err=1 plus frame_error for each. Preamble nibble 7 -> DROP, frame_error, no beats.
- rst asserted mid-frame at byte 10, released with dv high -> no beats until dv low. The next good frame is received intact.

Source files
------------

// File: rtl/axis_mii_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_mii_rx_pkg
//  Description : Ethernet framing and CRC constants shared by the MII TX and
//                RX MACs, plus the RX MAC state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_mii_rx_pkg;

    // Ethernet CRC-32: reflected Galois form, all-ones preset, fixed residue
    localparam logic [31:0] CRC_INIT    = 32'hffff_ffff;
    localparam logic [31:0] CRC_POLY    = 32'h04c1_1db7;
    localparam logic [31:0] CRC_RESIDUE = 32'hdebb_20e3;

    // Preamble and start-of-frame delimiter bytes (sent low nibble first)
    localparam logic [7:0]  DATA_PREAMBLE = 8'h55;
    localparam logic [7:0]  DATA_SFD      = 8'hd5;

    // Frame length limits, destination address through FCS inclusive
    localparam int ETH_MIN_FRAME_BYTES = 64;
    localparam int ETH_MAX_FRAME_BYTES = 1518;
    localparam int FCS_BYTES           = 4;

    // Receive byte counter width (saturating)
    localparam int RX_CNT_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_t;

endpackage : axis_mii_rx_pkg
`default_nettype wire

// File: rtl/lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr
//  Description : Combinational Galois LFSR / CRC step. Advances state_in by
//                DATA_WIDTH input bits in one cycle. REVERSE selects the
//                LSB-first (reflected) form used by Ethernet.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr #(
    parameter int                    LFSR_WIDTH = 32,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = 32'h04c1_1db7,
    parameter bit                    REVERSE    = 1'b1,
    parameter int                    DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [LFSR_WIDTH-1:0] state_in,
    output logic [LFSR_WIDTH-1:0] state_out
);

    function automatic logic [LFSR_WIDTH-1:0] bit_rev(input logic [LFSR_WIDTH-1:0] v);
        logic [LFSR_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < LFSR_WIDTH; i++) begin
            r[i] = v[LFSR_WIDTH-1-i];
        end
        return r;
    endfunction

    // Reflected form shifts right, so the taps are mirrored
    localparam logic [LFSR_WIDTH-1:0] c_POLY_REV = bit_rev(LFSR_POLY);

    logic [LFSR_WIDTH-1:0] w_state;
    logic                  w_fb;

    // Unrolled bit-serial Galois update over the whole input word
    always_comb begin
        w_state = state_in;
        w_fb    = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (REVERSE) begin
                w_fb    = w_state[0] ^ data_in[i];
                w_state = w_state >> 1;
                if (w_fb) begin
                    w_state = w_state ^ c_POLY_REV;
                end
            end else begin
                w_fb    = w_state[LFSR_WIDTH-1] ^ data_in[DATA_WIDTH-1-i];
                w_state = w_state << 1;
                if (w_fb) begin
                    w_state = w_state ^ LFSR_POLY;
                end
            end
        end
        state_out = w_state;
    end

endmodule : lfsr
`default_nettype wire

// File: rtl/axis_mii_rx.sv
`default_nettype none
// ============================================================================
//  Module      : axis_mii_rx
//  Description : 100M MII receive MAC. Finds preamble/SFD, assembles bytes,
//                checks FCS/length/alignment and streams frame data out on an
//                AXI-stream style port (no backpressure) with per-frame
//                status pulses.
//  Options     : AXIS_MII_RX_KEEP_FCS_EN - when defined the four FCS bytes
//                are passed through as data instead of being stripped.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_mii_rx
    import axis_mii_rx_pkg::*;
#(
    parameter int MAX_FRAME_BYTES = ETH_MAX_FRAME_BYTES,
    parameter int MIN_FRAME_BYTES = ETH_MIN_FRAME_BYTES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mii_rx_ce,
    input  logic       mii_rx_dv,
    input  logic       mii_rx_er,
    input  logic [3:0] mii_rxd,
    output logic [7:0] axis_data,
    output logic       axis_valid,
    output logic       axis_last,
    output logic       axis_err,
    output logic       frame_ok,
    output logic       fcs_error,
    output logic       frame_error,
    output logic       too_long
);

    // Bytes held back so that the FCS never reaches the stream
`ifdef AXIS_MII_RX_KEEP_FCS_EN
    localparam int c_DLY_BYTES = 0;
`else
    localparam int c_DLY_BYTES = FCS_BYTES;
`endif

    localparam logic [RX_CNT_W-1:0] c_PEND_CNT = RX_CNT_W'(c_DLY_BYTES + 1);
    localparam logic [RX_CNT_W-1:0] c_OVF_CNT  = RX_CNT_W'(MAX_FRAME_BYTES + 1);
    localparam logic [RX_CNT_W-1:0] c_MIN_CNT  = RX_CNT_W'(MIN_FRAME_BYTES);

    rx_state_t             r_state;
    rx_state_t             w_state_nxt;

    logic [3:0]            r_lo;
    logic                  r_phase;
    logic [RX_CNT_W-1:0]   r_cnt;
    logic                  r_err;
    logic [31:0]           r_crc;
    logic [7:0]            r_pend;

    logic [7:0]            w_byte;
    logic [7:0]            w_disp;
    logic [31:0]           w_crc_nxt;
    logic [RX_CNT_W-1:0]   w_cnt_inc;
    logic                  w_pend_vld;
    logic                  w_fcs_bad;
    logic                  w_frame_bad;

    logic                  w_start;
    logic                  w_nib;
    logic                  w_byte_done;
    logic                  w_beat;
    logic                  w_last;
    logic                  w_beat_err;
    logic                  w_ok;
    logic                  w_fcs_err;
    logic                  w_frm_err;
    logic                  w_long;

    logic [7:0]            r_axis_data;
    logic                  r_axis_valid;
    logic                  r_axis_last;
    logic                  r_axis_err;
    logic                  r_frame_ok;
    logic                  r_fcs_error;
    logic                  r_frame_error;
    logic                  r_too_long;

    // High nibble arrives second and completes the byte
    assign w_byte      = {mii_rxd, r_lo};
    assign w_cnt_inc   = (r_cnt == {RX_CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
    // The pending register only holds frame data once the delay line is full
    assign w_pend_vld  = (r_cnt >= c_PEND_CNT);
    assign w_fcs_bad   = (r_crc != CRC_RESIDUE);
    assign w_frame_bad = r_err | r_phase | (r_cnt < c_MIN_CNT);

    lfsr #(
        .LFSR_WIDTH (32),
        .LFSR_POLY  (CRC_POLY),
        .REVERSE    (1'b1),
        .DATA_WIDTH (8)
    ) u_crc (
        .data_in   (w_byte),
        .state_in  (r_crc),
        .state_out (w_crc_nxt)
    );

    generate
        if (c_DLY_BYTES > 0) begin : g_fcs_strip
            logic [7:0] r_dly [c_DLY_BYTES];

            // FCS delay line: each completed byte shifts in, oldest falls out to pending
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < c_DLY_BYTES; i++) begin
                        r_dly[i] <= 8'h00;
                    end
                end else if (w_byte_done) begin
                    r_dly[0] <= w_byte;
                    for (int i = 1; i < c_DLY_BYTES; i++) begin
                        r_dly[i] <= r_dly[i-1];
                    end
                end
            end

            assign w_disp = r_dly[c_DLY_BYTES-1];
        end else begin : g_fcs_keep
            assign w_disp = w_byte;
        end
    endgenerate

    // State register; reset lands in DROP so a frame in flight is ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_DROP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, datapath strobes and beat/status decode
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_nib       = 1'b0;
        w_byte_done = 1'b0;
        w_beat      = 1'b0;
        w_last      = 1'b0;
        w_beat_err  = 1'b0;
        w_ok        = 1'b0;
        w_fcs_err   = 1'b0;
        w_frm_err   = 1'b0;
        w_long      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (mii_rx_ce && mii_rx_dv) begin
                    if (mii_rxd == DATA_PREAMBLE[3:0]) begin
                        w_state_nxt = ST_PREAMBLE;
                    end else begin
                        w_state_nxt = ST_DROP;
                        w_frm_err   = 1'b1;
                    end
                end
            end

            ST_PREAMBLE: begin
                if (mii_rx_ce) begin
                    if (!mii_rx_dv) begin
                        // Carrier lost inside the preamble: silently back to idle
                        w_state_nxt = ST_IDLE;
                    end else if (mii_rxd == DATA_SFD[7:4]) begin
                        w_state_nxt = ST_DATA;
                        w_start     = 1'b1;
                    end else if (mii_rxd != DATA_PREAMBLE[3:0]) begin
                        w_state_nxt = ST_DROP;
                        w_frm_err   = 1'b1;
                    end
                end
            end

            ST_DATA: begin
                if (mii_rx_ce) begin
                    if (mii_rx_dv) begin
                        w_nib = 1'b1;
                        if (r_phase) begin
                            w_byte_done = 1'b1;
                            w_beat      = w_pend_vld;
                            if (w_cnt_inc == c_OVF_CNT) begin
                                // Oversize wins over any later end-of-frame evaluation
                                w_last      = w_pend_vld;
                                w_beat_err  = w_pend_vld;
                                w_long      = 1'b1;
                                w_frm_err   = 1'b1;
                                w_state_nxt = ST_DROP;
                            end
                        end
                    end else begin
                        // End of frame: flush pending as the last beat with verdict
                        w_state_nxt = ST_IDLE;
                        if (w_pend_vld) begin
                            w_beat     = 1'b1;
                            w_last     = 1'b1;
                            w_beat_err = w_frame_bad | w_fcs_bad;
                        end
                        if (w_frame_bad || !w_pend_vld) begin
                            w_frm_err = 1'b1;
                        end else if (w_fcs_bad) begin
                            w_fcs_err = 1'b1;
                        end else begin
                            w_ok = 1'b1;
                        end
                    end
                end
            end

            ST_DROP: begin
                if (mii_rx_ce && !mii_rx_dv) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_DROP;
            end
        endcase
    end

    // Nibble assembly, CRC, byte count, sticky error and pending byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lo    <= 4'h0;
            r_phase <= 1'b0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_crc   <= CRC_INIT;
            r_pend  <= 8'h00;
        end else if (w_start) begin
            r_phase <= 1'b0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_crc   <= CRC_INIT;
        end else if (w_nib) begin
            if (mii_rx_er) begin
                r_err <= 1'b1;
            end
            if (!r_phase) begin
                r_lo    <= mii_rxd;
                r_phase <= 1'b1;
            end else begin
                r_phase <= 1'b0;
                r_crc   <= w_crc_nxt;
                r_cnt   <= w_cnt_inc;
                r_pend  <= w_disp;
            end
        end
    end

    // Registered stream beat and single-cycle status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_axis_data   <= 8'h00;
            r_axis_valid  <= 1'b0;
            r_axis_last   <= 1'b0;
            r_axis_err    <= 1'b0;
            r_frame_ok    <= 1'b0;
            r_fcs_error   <= 1'b0;
            r_frame_error <= 1'b0;
            r_too_long    <= 1'b0;
        end else begin
            if (w_beat) begin
                r_axis_data <= r_pend;
            end
            r_axis_valid  <= w_beat;
            r_axis_last   <= w_beat & w_last;
            r_axis_err    <= w_beat & w_last & w_beat_err;
            r_frame_ok    <= w_ok;
            r_fcs_error   <= w_fcs_err;
            r_frame_error <= w_frm_err;
            r_too_long    <= w_long;
        end
    end

    assign axis_data   = r_axis_data;
    assign axis_valid  = r_axis_valid;
    assign axis_last   = r_axis_last;
    assign axis_err    = r_axis_err;
    assign frame_ok    = r_frame_ok;
    assign fcs_error   = r_fcs_error;
    assign frame_error = r_frame_error;
    assign too_long    = r_too_long;

endmodule : axis_mii_rx
`default_nettype wire

// File: tb/tb_axis_mii_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_axis_mii_rx
//  Description : Self-checking bench for axis_mii_rx. Directed MII frames are
//                driven nibble by nibble; a queue model derives the expected
//                beats and status from each frame's bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_mii_rx;

    localparam int MAXB = 1518;
    localparam int MINB = 64;
`ifdef AXIS_MII_RX_KEEP_FCS_EN
    localparam int DLY = 0;
`else
    localparam int DLY = 4;
`endif
    localparam logic [31:0] RESIDUE = 32'hdebb_20e3;

    typedef logic [7:0] byteq_t[$];
    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       err;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce  = 1'b0;
    logic       dv  = 1'b0;
    logic       er  = 1'b0;
    logic [3:0] rxd = 4'h0;

    logic [7:0] axis_data;
    logic       axis_valid;
    logic       axis_last;
    logic       axis_err;
    logic       frame_ok;
    logic       fcs_error;
    logic       frame_error;
    logic       too_long;

    axis_mii_rx dut (
        .clk         (clk),
        .rst         (rst),
        .mii_rx_ce   (ce),
        .mii_rx_dv   (dv),
        .mii_rx_er   (er),
        .mii_rxd     (rxd),
        .axis_data   (axis_data),
        .axis_valid  (axis_valid),
        .axis_last   (axis_last),
        .axis_err    (axis_err),
        .frame_ok    (frame_ok),
        .fcs_error   (fcs_error),
        .frame_error (frame_error),
        .too_long    (too_long)
    );

    always #5 clk = ~clk;

    int     errors = 0;
    int     checks = 0;

    byteq_t frm;
    beat_t  exp_beats[$];
    // {beat_with_last, frame_ok, fcs_error, frame_error, too_long}
    logic [4:0] exp_stat[$];

    int         beat_cnt;
    int         stat_cnt;
    logic       last_err;
    logic [4:0] stat_or;

    // Standard reflected CRC-32 over a byte queue, no final inversion
    function automatic logic [31:0] crc_q(input byteq_t q);
        logic [31:0] c;
        c = 32'hffff_ffff;
        foreach (q[i]) begin
            c = c ^ {24'h0, q[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hedb8_8320) : (c >> 1);
            end
        end
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    // Compare process: every output beat and every status pulse against the model
    always @(negedge clk) begin
        beat_t      e;
        logic [4:0] st;
        st = {axis_valid & axis_last, frame_ok, fcs_error, frame_error, too_long};
        if (axis_valid) begin
            beat_cnt++;
            if (axis_last) last_err = axis_err;
            checks++;
            if (exp_beats.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got data=%02h last=%0b err=%0b, required no beat",
                         axis_data, axis_last, axis_err);
            end else begin
                e = exp_beats.pop_front();
                if ({axis_data, axis_last, axis_err} !== e) begin
                    errors++;
                    $display("FAIL beat: got data=%02h last=%0b err=%0b, required data=%02h last=%0b err=%0b",
                             axis_data, axis_last, axis_err, e.d, e.last, e.err);
                end
            end
        end else if (axis_last || axis_err) begin
            checks++;
            errors++;
            $display("FAIL idle_flags: got last=%0b err=%0b without valid, required 0", axis_last, axis_err);
        end
        if (st[3:0] != 4'b0000) begin
            stat_cnt++;
            stat_or = stat_or | st;
            checks++;
            if (exp_stat.size() == 0) begin
                errors++;
                $display("FAIL status_unexpected: got %05b, required none", st);
            end else if (st !== exp_stat[0]) begin
                errors++;
                $display("FAIL status: got %05b, required %05b", st, exp_stat[0]);
                void'(exp_stat.pop_front());
            end else begin
                void'(exp_stat.pop_front());
            end
        end
    end

    // Model: expected beats and status from the bytes the MAC will see
    task automatic model_frame(input int flip_idx, input int er_idx, input bit extra_nib);
        byteq_t     b;
        int         n;
        int         nb;
        logic       bad;
        logic       fbad;
        b = frm;
        if (flip_idx >= 0) b[flip_idx] = b[flip_idx] ^ 8'h01;
        n = b.size();
        if (n > MAXB) begin
            nb = MAXB - DLY;
            for (int i = 0; i < nb; i++) exp_beats.push_back({b[i], (i == nb-1), (i == nb-1)});
            exp_stat.push_back(5'b10011);
        end else begin
            fbad = (crc_q(b) != RESIDUE);
            bad  = (er_idx >= 0) || extra_nib || (n < MINB);
            if (n > DLY) begin
                nb = n - DLY;
                for (int i = 0; i < nb; i++)
                    exp_beats.push_back({b[i], (i == nb-1), (i == nb-1) && (bad || fbad)});
                exp_stat.push_back(bad ? 5'b10010 : (fbad ? 5'b10100 : 5'b11000));
            end else begin
                exp_stat.push_back(5'b00010);
            end
        end
    endtask

    task automatic nib(input logic [3:0] d, input logic v, input logic e);
        @(posedge clk); #1;
        rxd = d; dv = v; er = e; ce = 1'b1;
        @(posedge clk); #1;
        ce = 1'b0; er = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic make_frame(input int payload, input bit add_fcs);
        logic [31:0] c;
        frm.delete();
        for (int i = 0; i < payload; i++) frm.push_back(8'((i * 7 + 3) & 8'hff));
        if (add_fcs) begin
            c = ~crc_q(frm);
            for (int k = 0; k < 4; k++) frm.push_back(c[8*k +: 8]);
        end
    endtask

    task automatic send_frame(input int flip_idx, input int er_idx, input bit extra_nib,
                              input bit bad_pre, input int rst_at);
        logic [7:0] v;
        for (int i = 0; i < 15; i++) nib((bad_pre && i == 2) ? 4'h7 : 4'h5, 1'b1, 1'b0);
        nib(4'hd, 1'b1, 1'b0);
        for (int i = 0; i < frm.size(); i++) begin
            v = frm[i];
            if (i == flip_idx) v = v ^ 8'h01;
            nib(v[3:0], 1'b1, (i == er_idx));
            if (i == rst_at) begin
                @(posedge clk); #1 rst = 1'b1;
                repeat (3) @(posedge clk);
                #1 rst = 1'b0;
            end
            nib(v[7:4], 1'b1, 1'b0);
        end
        if (extra_nib) nib(4'h3, 1'b1, 1'b0);
        repeat (3) nib(4'h0, 1'b0, 1'b0);
    endtask

    task automatic run_frame(input string name, input int flip_idx, input int er_idx,
                             input bit extra_nib, input bit bad_pre, input int rst_at);
        beat_cnt = 0;
        stat_cnt = 0;
        last_err = 1'b0;
        stat_or  = 5'b00000;
        if (bad_pre) begin
            exp_stat.push_back(5'b00010);
        end else if (rst_at >= 0) begin
            for (int i = 0; i < rst_at - DLY - 1; i++) exp_beats.push_back({frm[i], 1'b0, 1'b0});
        end else begin
            model_frame(flip_idx, er_idx, extra_nib);
        end
        send_frame(flip_idx, er_idx, extra_nib, bad_pre, rst_at);
        checks++;
        if (exp_beats.size() != 0 || exp_stat.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: got %0d beats and %0d status left over, required 0 and 0",
                     name, exp_beats.size(), exp_stat.size());
        end
        exp_beats.delete();
        exp_stat.delete();
    endtask

    initial begin
        byteq_t q;

        beat_cnt = 0;
        stat_cnt = 0;
        last_err = 1'b0;
        stat_or  = 5'b00000;

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {16'h0, axis_data, axis_valid, axis_last, axis_err,
                              frame_ok, fcs_error, frame_error, too_long}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) nib(4'h0, 1'b0, 1'b0);

        // Pin the model's CRC against the published check value and residue
        q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        chk("crc_check_value", ~crc_q(q), 32'hcbf4_3926);
        make_frame(60, 1'b1);
        chk("fcs_residue", crc_q(frm), 32'hdebb_20e3);

        // Minimum-size good frame
        run_frame("good64", -1, -1, 1'b0, 1'b0, -1);
        chk("good64_beats", beat_cnt, 64 - DLY);
        chk("good64_last_err", {31'h0, last_err}, 0);
        chk("good64_status", {27'h0, stat_or}, 5'b11000);
        chk("good64_status_cnt", stat_cnt, 1);

        // Bit 0 of byte 20 corrupted on the wire
        run_frame("flip20", 20, -1, 1'b0, 1'b0, -1);
        chk("flip20_beats", beat_cnt, 64 - DLY);
        chk("flip20_last_err", {31'h0, last_err}, 1);
        chk("flip20_status", {27'h0, stat_or}, 5'b10100);

        // rx_er for one nibble at byte 30 of a 100-byte frame
        make_frame(96, 1'b1);
        run_frame("rxer", -1, 29, 1'b0, 1'b0, -1);
        chk("rxer_beats", beat_cnt, 100 - DLY);
        chk("rxer_last_err", {31'h0, last_err}, 1);
        chk("rxer_status", {27'h0, stat_or}, 5'b10010);

        // Largest legal frame
        make_frame(1514, 1'b1);
        run_frame("max", -1, -1, 1'b0, 1'b0, -1);
        chk("max_beats", beat_cnt, 1518 - DLY);
        chk("max_status", {27'h0, stat_or}, 5'b11000);

        // One byte over the limit
        make_frame(1515, 1'b1);
        run_frame("oversize", -1, -1, 1'b0, 1'b0, -1);
        chk("oversize_beats", beat_cnt, 1518 - DLY);
        chk("oversize_last_err", {31'h0, last_err}, 1);
        chk("oversize_status", {27'h0, stat_or}, 5'b10011);

        // Odd nibble count after a valid 64-byte frame
        make_frame(60, 1'b1);
        run_frame("odd", -1, -1, 1'b1, 1'b0, -1);
        chk("odd_beats", beat_cnt, 64 - DLY);
        chk("odd_last_err", {31'h0, last_err}, 1);
        chk("odd_status", {27'h0, stat_or}, 5'b10010);

        // 40-byte runt with correct FCS
        make_frame(36, 1'b1);
        run_frame("runt", -1, -1, 1'b0, 1'b0, -1);
        chk("runt_beats", beat_cnt, 40 - DLY);
        chk("runt_last_err", {31'h0, last_err}, 1);
        chk("runt_status", {27'h0, stat_or}, 5'b10010);

        // Three bytes only: too short to produce a beat
        make_frame(3, 1'b0);
        run_frame("tiny", -1, -1, 1'b0, 1'b0, -1);
        chk("tiny_status", {27'h0, stat_or}, (DLY > 0) ? 32'h02 : 32'h12);

        // Bad preamble nibble
        make_frame(60, 1'b1);
        run_frame("badpre", -1, -1, 1'b0, 1'b1, -1);
        chk("badpre_beats", beat_cnt, 0);
        chk("badpre_status", {27'h0, stat_or}, 5'b00010);

        // Reset mid-frame at byte 10, released with dv still high
        run_frame("midrst", -1, -1, 1'b0, 1'b0, 9);
        chk("midrst_beats", beat_cnt, 9 - DLY - 1 > 0 ? 9 - DLY - 1 : 0);
        chk("midrst_status_cnt", stat_cnt, 0);

        // Following good frame arrives intact
        run_frame("after_rst", -1, -1, 1'b0, 1'b0, -1);
        chk("after_rst_beats", beat_cnt, 64 - DLY);
        chk("after_rst_status", {27'h0, stat_or}, 5'b11000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_axis_mii_rx
`default_nettype wire
